// File: rtl/pwm_mode_ctrl.sv
// pwm_mode_ctrl: debounces the two push-buttons and sequences the PWM
// datapath configuration (period, threshold, enable). Mode changes take effect
// at period boundaries, and threshold moves between running modes are ramped.
module pwm_mode_ctrl #(
  parameter int PERIOD_A   = 500,
  parameter int THRESH_A   = 200,
  parameter int PERIOD_B   = 625,
  parameter int THRESH_B   = 400,
  parameter int RAMP_STEP  = 50,
  parameter int DEB_CYCLES = 50000,
  parameter int W          = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         key0,
  input  logic         key1,
  input  logic         period_end,
  output logic         pwm_en,
  output logic [W-1:0] period,
  output logic [W-1:0] threshold,
  output logic         busy,
  output logic         led0,
  output logic         led1
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

  localparam logic [W-1:0] PER_A = W'(PERIOD_A);
  localparam logic [W-1:0] THR_A = W'(THRESH_A);
  localparam logic [W-1:0] PER_B = W'(PERIOD_B);
  localparam logic [W-1:0] THR_B = W'(THRESH_B);
  localparam logic [W-1:0] STEP  = W'(RAMP_STEP);

  typedef enum logic [1:0] {S_IDLE, S_A, S_B} state_t;
  typedef enum logic [1:0] {R_NONE, R_A, R_B, R_STOP} req_t;

  // Target threshold of a mode; IDLE reports mode A's value (unused there).
  function automatic logic [W-1:0] target_of(input state_t s);
    target_of = (s == S_B) ? THR_B : THR_A;
  endfunction

  // One ramp step toward tgt, limited to STEP, never overshooting and
  // computed from the ordered difference so nothing can wrap.
  function automatic logic [W-1:0] ramp_toward(input logic [W-1:0] cur,
                                               input logic [W-1:0] tgt);
    logic [W-1:0] gap;
    if (cur < tgt) begin
      gap = tgt - cur;
      ramp_toward = (gap > STEP) ? cur + STEP : tgt;
    end else begin
      gap = cur - tgt;
      ramp_toward = (gap > STEP) ? cur - STEP : tgt;
    end
  endfunction

  // Keeps the threshold inside the new counter range.
  function automatic logic [W-1:0] clamp_to(input logic [W-1:0] thr,
                                            input logic [W-1:0] per);
    clamp_to = (thr > per) ? per : thr;
  endfunction

  logic [1:0]       keys;
  logic [1:0]       sync_p0;
  logic [1:0]       sync_p1;
  logic [1:0]       deb_p2;
  logic [1:0]       deb_p3;
  logic [CNT_W-1:0] deb_cnt [2];
  logic [1:0]       press;

  state_t           state_q, state_d;
  req_t             pend_q, pend_d, pend_eff, req;
  logic [W-1:0]     period_q, period_d;
  logic [W-1:0]     thr_q, thr_d;
  logic             en_q, en_d;
  logic             led0_q, led0_d;
  logic             led1_q, led1_d;
  logic             busy_q, busy_d;

  assign keys = {key1, key0};

  // ---- stage p0/p1: two-flop synchronizer for the raw buttons
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 2'b11;
      sync_p1 <= 2'b11;
    end else begin
      sync_p0 <= keys;
      sync_p1 <= sync_p0;
    end
  end

  // ---- stage p2: accept a new level after DEB_CYCLES differing samples
  always_ff @(posedge clk) begin
    if (rst) begin
      deb_p2 <= 2'b11;
      for (int i = 0; i < 2; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (sync_p1[i] == deb_p2[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb_p2[i]  <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + 1'b1;
        end
      end
    end
  end

  // ---- stage p3: delayed debounced level for falling-edge (press) detect
  always_ff @(posedge clk) begin
    if (rst) deb_p3 <= 2'b11;
    else     deb_p3 <= deb_p2;
  end

  assign press = deb_p3 & ~deb_p2;

  // Decode a single press into a request; simultaneous presses cancel out.
  always_comb begin
    req = R_NONE;
    if (press[0] ^ press[1]) begin
      case (state_q)
        S_IDLE:  req = press[0] ? R_A : R_B;
        S_A:     req = press[1] ? R_B : R_STOP;
        S_B:     req = press[0] ? R_A : R_STOP;
        default: req = R_NONE;
      endcase
    end
  end

  // Next-state and next-configuration logic of the mode FSM.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    pend_eff = pend_q;
    period_d = period_q;
    thr_d    = thr_q;
    en_d     = en_q;
    led0_d   = led0_q;
    led1_d   = led1_q;
    case (state_q)
      S_IDLE: begin
        // Datapath is stopped, so a start needs no period alignment.
        if (req == R_A) begin
          state_d  = S_A;
          period_d = PER_A;
          thr_d    = THR_A;
          en_d     = 1'b1;
          led0_d   = 1'b1;
          led1_d   = 1'b0;
          pend_d   = R_NONE;
        end else if (req == R_B) begin
          state_d  = S_B;
          period_d = PER_B;
          thr_d    = THR_B;
          en_d     = 1'b1;
          led0_d   = 1'b0;
          led1_d   = 1'b1;
          pend_d   = R_NONE;
        end
      end
      default: begin
        // Newest request wins; applied only on a period boundary.
        if (req != R_NONE) pend_eff = req;
        pend_d = pend_eff;
        if (period_end) begin
          case (pend_eff)
            R_STOP: begin
              state_d = S_IDLE;
              en_d    = 1'b0;
              led0_d  = 1'b0;
              led1_d  = 1'b0;
              pend_d  = R_NONE;
            end
            R_A: begin
              state_d  = S_A;
              period_d = PER_A;
              thr_d    = clamp_to(thr_q, PER_A);
              led0_d   = 1'b1;
              led1_d   = 1'b0;
              pend_d   = R_NONE;
            end
            R_B: begin
              state_d  = S_B;
              period_d = PER_B;
              thr_d    = clamp_to(thr_q, PER_B);
              led0_d   = 1'b0;
              led1_d   = 1'b1;
              pend_d   = R_NONE;
            end
            default: thr_d = ramp_toward(thr_q, target_of(state_q));
          endcase
        end
      end
    endcase
    busy_d = (state_d != S_IDLE) && (thr_d != target_of(state_d));
  end

  // Registered FSM state and datapath configuration.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      pend_q   <= R_NONE;
      period_q <= PER_A;
      thr_q    <= THR_A;
      en_q     <= 1'b0;
      led0_q   <= 1'b0;
      led1_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      period_q <= period_d;
      thr_q    <= thr_d;
      en_q     <= en_d;
      led0_q   <= led0_d;
      led1_q   <= led1_d;
      busy_q   <= busy_d;
    end
  end

  assign pwm_en    = en_q;
  assign period    = period_q;
  assign threshold = thr_q;
  assign busy      = busy_q;
  assign led0      = led0_q;
  assign led1      = led1_q;

endmodule
